fdiv_seq: RTL and testbench
===========================

FDIV_SEQ -- requirements
Module: fdiv_seq

Interface
REQ-001 SHALL have parameter EARLY_SPECIAL, default 1: when 1, special-case operations complete without iterating.
REQ-002 SHALL have port clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operands a, b present.
REQ-005 SHALL have port in_ready  output  1  unit accepts operands.
REQ-006 SHALL have port a  input  32  dividend, IEEE-754 single.
REQ-007 SHALL have port b  input  32  divisor, IEEE-754 single.
REQ-008 SHALL have port out_valid  output  1  result s valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes s.
REQ-010 SHALL have port s  output  32  quotient a/b, IEEE-754 single.

Function
REQ-011 SHALL implement a four-state FSM: IDLE, DIV, NORM, OUT.
REQ-012 SHALL assert in_ready only in IDLE; handshake is in_valid&&in_ready at a clk edge, which latches a and b.
REQ-013 SHALL, on handshake, go to DIV with mantissas ma={1,a[22:0]} and mb={1,b[22:0]}, sign a[31]^b[31], and 10-bit signed exponent difference a[30:23]-b[30:23].
REQ-014 SHALL, in DIV, run restoring division producing one quotient bit per cycle, 25 bits total, q = floor(ma*2^24/mb), using a 5-bit iteration counter, then go to NORM.
REQ-015 SHALL, in NORM: if q[24]=1, set exponent = diff+127 and fraction = q[23:1]; else set exponent = diff+126 and fraction = q[22:0]. Rounding is truncation only.
REQ-016 SHALL, in NORM: exponent >= 255 gives signed infinity, fraction 0; exponent <= 0 gives signed zero (flush, no denormal output).
REQ-017 SHALL treat an operand with exponent field 0 as zero; denormal fraction bits are ignored.
REQ-018 SHALL apply specials, priority order:
- either operand NaN -> 0x7FC00000;
- inf/inf or 0/0 -> 0x7FC00000;
- inf/x -> signed inf;
- x/0 -> signed inf;
- 0/x or x/inf -> signed zero.
REQ-019 SHALL, when EARLY_SPECIAL=1 and a special applies, go from handshake directly to OUT (out_valid after handshake edge +1); otherwise specials are resolved in NORM with normal latency.
REQ-020 SHALL have normal latency: out_valid high after handshake edge +27 (25 DIV cycles, 1 NORM, then OUT).
REQ-021 SHALL, in OUT, hold out_valid=1 and s stable until out_valid&&out_ready at an edge, then return to IDLE; in_ready stays 0 throughout OUT.
REQ-022 SHALL not overlap operations: a new handshake cannot occur in the same cycle as output acceptance (minimum one IDLE cycle).
REQ-023 SHALL ignore in_valid and operand changes outside IDLE.

Reset
REQ-024 SHALL, on rst_n low, immediately force state IDLE, out_valid=0, s=0, counter=0, and all datapath registers to 0, including mid-DIV or mid-OUT; an in-flight result is discarded.
REQ-025 SHALL have in_ready=1 on the first edge after rst_n deasserts.

Structure
REQ-026 SHALL take the FSM state encoding and the constants QNAN=0x7FC00000, EXP_BIAS=127, and MANT_W=24 from the shared fpu package fpu_pkg.
REQ-027 SHALL instantiate one sub-module, fdiv_special (combinational special-case classifier, operands to {is_special, special_result}); the iterative datapath stays in fdiv_seq.

Verification
REQ-028 SHALL cover: a=0x40C00000 (6), b=0x40400000 (3) -> s=0x40000000, out_valid at handshake edge +27.
REQ-029 SHALL cover: a=0x3F800000, b=0x40400000 -> s=0x3EAAAAAA (truncated, not 0x3EAAAAAB).
REQ-030 SHALL cover: a=0xBF800000, b=0x00000000 -> s=0xFF800000, latency 1 with EARLY_SPECIAL=1 and 27 with EARLY_SPECIAL=0; a=0x7F800000, b=0x7F800000 -> 0x7FC00000.
REQ-031 SHALL cover: a=0x7F000000, b=0x3E800000 -> 0x7F800000 (overflow); a=0x00800000, b=0x7F000000 -> 0x00000000 (underflow flush).
REQ-032 SHALL cover: out_ready held 0 for 10 cycles in OUT -> s and out_valid stable, in_ready=0, and a second in_valid is not accepted until one cycle after output acceptance.
REQ-033 SHALL cover: rst_n pulsed low at DIV cycle 12 -> out_valid=0 immediately, in_ready=1 after release, and the next 6/3 division returns correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: divider FSM encoding and IEEE-754 constants.
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_NORM = 2'd2,
    ST_OUT  = 2'd3
  } fdiv_state_e;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam int          EXP_BIAS = 127;
  localparam int          MANT_W   = 24;

endpackage

// File: rtl/fdiv_special.sv
// Combinational classifier for divide special cases (NaN, infinity, zero operands).
module fdiv_special
  import fpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        is_special_o,
  output logic [31:0] special_result_o
);

  logic sign_s;
  logic a_zero_s, a_inf_s, a_nan_s;
  logic b_zero_s, b_inf_s, b_nan_s;

  assign sign_s   = a_i[31] ^ b_i[31];
  // Exponent field 0 counts as zero; denormal fraction bits are deliberately ignored.
  assign a_zero_s = (a_i[30:23] == 8'h00);
  assign b_zero_s = (b_i[30:23] == 8'h00);
  assign a_inf_s  = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'h0);
  assign b_inf_s  = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'h0);
  assign a_nan_s  = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'h0);
  assign b_nan_s  = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'h0);

  // Priority-ordered special-case resolution
  always_comb begin
    is_special_o     = 1'b1;
    special_result_o = QNAN;
    if (a_nan_s || b_nan_s) begin
      special_result_o = QNAN;
    end else if ((a_inf_s && b_inf_s) || (a_zero_s && b_zero_s)) begin
      special_result_o = QNAN;
    end else if (a_inf_s || b_zero_s) begin
      special_result_o = {sign_s, 8'hFF, 23'h0};
    end else if (a_zero_s || b_inf_s) begin
      special_result_o = {sign_s, 31'h0};
    end else begin
      is_special_o     = 1'b0;
      special_result_o = 32'h0;
    end
  end

endmodule

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 single divider: one restoring-division quotient bit per cycle,
// truncating rounding, flush-to-zero on underflow.
module fdiv_seq
  import fpu_pkg::*;
#(
  parameter int EARLY_SPECIAL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] s
);

  fdiv_state_e        state_q;
  logic [4:0]         cnt_q;
  logic [MANT_W-1:0]  mb_q;
  logic [MANT_W:0]    rem_q;
  logic [MANT_W:0]    quo_q;
  logic               sign_q;
  logic signed [9:0]  diff_q;
  logic               spec_q;
  logic [31:0]        spec_res_q;
  logic               out_valid_q;
  logic [31:0]        s_q;

  logic               is_special_s;
  logic [31:0]        special_result_s;
  logic               ge_s;
  logic [MANT_W:0]    rem_sub_s;
  logic signed [9:0]  exp_s;
  logic [22:0]        frac_s;
  logic [31:0]        norm_res_s;

  fdiv_special u_special (
    .a_i              (a),
    .b_i              (b),
    .is_special_o     (is_special_s),
    .special_result_o (special_result_s)
  );

  assign ge_s      = (rem_q >= {1'b0, mb_q});
  assign rem_sub_s = ge_s ? (rem_q - {1'b0, mb_q}) : rem_q;

  // Normalise the 25-bit quotient, then clamp exponent to inf/zero or apply a late special
  always_comb begin
    norm_res_s = 32'h0;
    if (quo_q[24]) begin
      exp_s  = diff_q + 10'(EXP_BIAS);
      frac_s = quo_q[23:1];
    end else begin
      exp_s  = diff_q + 10'(EXP_BIAS - 1);
      frac_s = quo_q[22:0];
    end
    if (spec_q) begin
      norm_res_s = spec_res_q;
    end else if (exp_s >= 10'sd255) begin
      norm_res_s = {sign_q, 8'hFF, 23'h0};
    end else if (exp_s <= 10'sd0) begin
      norm_res_s = {sign_q, 31'h0};
    end else begin
      norm_res_s = {sign_q, exp_s[7:0], frac_s};
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      mb_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      sign_q      <= 1'b0;
      diff_q      <= 10'sd0;
      spec_q      <= 1'b0;
      spec_res_q  <= 32'h0;
      out_valid_q <= 1'b0;
      s_q         <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          out_valid_q <= 1'b0;
          if (in_valid) begin
            mb_q       <= {1'b1, b[22:0]};
            rem_q      <= {2'b01, a[22:0]};
            quo_q      <= '0;
            cnt_q      <= 5'd0;
            sign_q     <= a[31] ^ b[31];
            diff_q     <= $signed({2'b00, a[30:23]} - {2'b00, b[30:23]});
            spec_q     <= is_special_s;
            spec_res_q <= special_result_s;
            if ((EARLY_SPECIAL != 0) && is_special_s) begin
              s_q     <= special_result_s;
              state_q <= ST_OUT;
            end else begin
              state_q <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          quo_q <= {quo_q[MANT_W-1:0], ge_s};
          rem_q <= rem_sub_s << 1;
          if (cnt_q == 5'd24) begin
            cnt_q   <= 5'd0;
            state_q <= ST_NORM;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        ST_NORM: begin
          s_q     <= norm_res_s;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          // out_valid rises one cycle after entering OUT, giving latency 1 / 27
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign s         = s_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// Randomised and directed bench for fdiv_seq, run on both EARLY_SPECIAL settings in lockstep.
module tb_fdiv_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_ready;
  logic        in_ready1, out_valid1;
  logic [31:0] s1;
  logic        in_ready0, out_valid0;
  logic [31:0] s0;

  int n_vec;
  int n_err;

  fdiv_seq #(.EARLY_SPECIAL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready), .s(s1)
  );

  fdiv_seq #(.EARLY_SPECIAL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready), .s(s0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Operand classification straight from the IEEE-754 field rules.
  function automatic bit is_spec(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'h00) || (y[30:23] == 8'h00) ||
           (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF);
  endfunction

  // Reference quotient computed with wide integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e;
    bit xz, yz, xi, yi, xn, yn;
    logic sg;
    longint unsigned ma, mb, q;
    logic [22:0] f;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    sg = x[31] ^ y[31];
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 23'h0);
    yi = (ey == 255) && (y[22:0] == 23'h0);
    xn = (ex == 255) && (x[22:0] != 23'h0);
    yn = (ey == 255) && (y[22:0] != 23'h0);
    if (xn || yn) return 32'h7FC00000;
    if ((xi && yi) || (xz && yz)) return 32'h7FC00000;
    if (xi || yz) return {sg, 8'hFF, 23'h0};
    if (xz || yi) return {sg, 31'h0};
    ma = 64'h800000 + 64'(x[22:0]);
    mb = 64'h800000 + 64'(y[22:0]);
    q  = (ma * 64'd16777216) / mb;
    if (q >= 64'd16777216) begin
      e = ex - ey + 127;
      f = q[23:1];
    end else begin
      e = ex - ey + 126;
      f = q[22:0];
    end
    if (e >= 255) return {sg, 8'hFF, 23'h0};
    if (e <= 0) return {sg, 31'h0};
    return {sg, e[7:0], f};
  endfunction

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 60 && !(in_ready1 && in_ready0); k++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_rdy"}, {31'h0, in_ready1 && in_ready0}, 32'd1);
  endtask

  // One transaction with out_ready high; checks result and latency on both DUTs.
  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input string tag);
    int lat1, lat0;
    logic [31:0] v1, v0, want;
    want = ref_div(xa, xb);
    wait_ready(tag);
    out_ready = 1'b1;
    a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat1 = -1; lat0 = -1; v1 = 32'h0; v0 = 32'h0;
    for (int c = 1; c <= 40 && (lat1 < 0 || lat0 < 0); c++) begin
      @(posedge clk); #1;
      if (out_valid1 && lat1 < 0) begin lat1 = c; v1 = s1; end
      if (out_valid0 && lat0 < 0) begin lat0 = c; v0 = s0; end
    end
    chk({tag, "_s_early"}, v1, want);
    chk({tag, "_lat_early"}, 32'(lat1), is_spec(xa, xb) ? 32'd1 : 32'd27);
    chk({tag, "_s_late"}, v0, want);
    chk({tag, "_lat_late"}, 32'(lat0), 32'd27);
  endtask

  logic [31:0] ra, rb;
  int lat;

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 32'h0; b = 32'h0;
    #12;
    chk("rst_ov", {31'h0, out_valid1}, 32'd0);
    chk("rst_s", s1, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_rdy", {31'h0, in_ready1}, 32'd1);

    do_op(32'h40C00000, 32'h40400000, "six_by_three");
    do_op(32'h3F800000, 32'h40400000, "third_trunc");
    do_op(32'hBF800000, 32'h00000000, "neg_by_zero");
    do_op(32'h7F800000, 32'h7F800000, "inf_by_inf");
    do_op(32'h7F000000, 32'h3E800000, "overflow");
    do_op(32'h00800000, 32'h7F000000, "underflow");
    do_op(32'h7FC12345, 32'h3F800000, "nan_a");
    do_op(32'h00000000, 32'h80000000, "zero_by_zero");
    do_op(32'h00412345, 32'h40000000, "denorm_a");
    do_op(32'hC0000000, 32'hFF800000, "x_by_inf");

    for (int i = 0; i < 30; i++) begin
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        ra[30:23] = 8'($urandom_range(40, 210));
        rb[30:23] = 8'($urandom_range(40, 210));
      end
      do_op(ra, rb, "random");
    end

    // Output stall: result held, no new operands taken until one cycle after acceptance
    wait_ready("stall");
    out_ready = 1'b0;
    a = 32'h40C00000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 40 && !(out_valid1 && out_valid0); k++) begin
      @(posedge clk); #1;
    end
    a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("stall_s", s1, 32'h40000000);
      chk("stall_ov", {31'h0, out_valid1}, 32'd1);
      chk("stall_rdy", {31'h0, in_ready1}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("acc_ov", {31'h0, out_valid1}, 32'd0);
    chk("acc_rdy", {31'h0, in_ready1}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hs2_rdy", {31'h0, in_ready1}, 32'd0);
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (out_valid1) lat = c;
    end
    chk("second_lat", 32'(lat), 32'd27);
    chk("second_s", s1, 32'h3EAAAAAA);

    // Reset in the middle of DIV discards the operation
    wait_ready("rstmid");
    a = 32'h40C00000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) begin @(posedge clk); end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", {31'h0, out_valid1}, 32'd0);
    chk("mid_rst_s", s1, 32'h0);
    chk("mid_rst_s_late", s0, 32'h0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rdy", {31'h0, in_ready1}, 32'd1);
    do_op(32'h40C00000, 32'h40400000, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
